// File: rtl/fp_addsub_ctrl.sv
// Sequencing controller for a multi-stage FP add/sub datapath: accepts one op,
// walks the stage enables, captures the result and holds it until consumed.
module fp_addsub_ctrl #(
    parameter int SPECIAL_BYPASS = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    input  logic             special_case,
    input  logic [31:0]      special_result,
    input  logic [31:0]      dp_result,
    input  logic [4:0]       dp_fflags,
    output logic             align_en,
    output logic             addsub_en,
    output logic             norm_en,
    output logic             round_en,
    output logic             op_q,
    output logic [2:0]       rm_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [4:0]       out_fflags,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        ADDSUB = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        DONE   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic             op_d;
    logic [2:0]       rm_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      res_q, res_d;
    logic [4:0]       flg_q, flg_d;
    logic             special_nv;

    // A quiet NaN out of the special path is the canonical invalid-op result.
    assign special_nv = (special_result[30:22] == 9'h1FF);

    assign in_ready   = (state_q == IDLE) && !flush;
    assign align_en   = (state_q == ALIGN);
    assign addsub_en  = (state_q == ADDSUB);
    assign norm_en    = (state_q == NORM);
    assign round_en   = (state_q == ROUND);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = res_q;
    assign out_fflags = flg_q;
    assign out_tag    = tag_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rm_d    = rm_q;
        tag_d   = tag_q;
        res_d   = res_q;
        flg_d   = flg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = ALIGN;
                    op_d    = in_op;
                    rm_d    = in_rm;
                    tag_d   = in_tag;
                end
            end
            ALIGN: begin
                if ((SPECIAL_BYPASS == 1) && special_case) begin
                    state_d = DONE;
                    res_d   = special_result;
                    flg_d   = {special_nv, 4'b0000};
                end else begin
                    state_d = ADDSUB;
                end
            end
            ADDSUB: state_d = NORM;
            NORM:   state_d = ROUND;
            ROUND: begin
                state_d = DONE;
                res_d   = dp_result;
                flg_d   = dp_fflags;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over completion and acceptance alike.
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            rm_q    <= 3'd0;
            tag_q   <= '0;
            res_q   <= 32'd0;
            flg_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rm_q    <= rm_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

endmodule
